// File: rtl/muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the iterative M-extension unit.
// The master issues operations; the slave (muldiv_unit) returns stall, done and result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            startE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            stallE;
  logic            doneE;
  logic [XLEN-1:0] resultE;

  modport master (
    output startE, funct3E, SrcAE, SrcBE, FlushE,
    input  stallE, doneE, resultE
  );

  modport slave (
    input  startE, funct3E, SrcAE, SrcBE, FlushE,
    output stallE, doneE, resultE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension execute unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction applied on the final step.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  state_t            state_r;
  logic [CW-1:0]     count_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   operand_r;
  logic [2:0]        funct3_r;
  logic              signA_r;
  logic              negRes_r;
  logic              divZero_r;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  logic              signedA_s;
  logic              signedB_s;
  logic              signA_s;
  logic              signB_s;
  logic              bZero_s;
  logic              overflow_s;
  logic              earlyOut_s;
  logic [XLEN-1:0]   absA_s;
  logic [XLEN-1:0]   absB_s;
  logic [XLEN-1:0]   earlyRes_s;

  logic [XLEN:0]     mulSum_s;
  logic [XLEN:0]     remSh_s;
  logic              remGe_s;
  logic [XLEN-1:0]   remDiff_s;
  logic [2*XLEN-1:0] stepAcc_s;
  logic [2*XLEN-1:0] prodFix_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   remd_s;
  logic [XLEN-1:0]   finalRes_s;

  // Request decode: operand signedness, magnitudes and the RISC-V division corner cases
  always_comb begin
    signedA_s = 1'b0;
    signedB_s = 1'b0;
    case (bus.funct3E)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signedA_s = 1'b1;
        signedB_s = 1'b1;
      end
      3'b010: begin
        signedA_s = 1'b1;
        signedB_s = 1'b0;
      end
      default: begin
        signedA_s = 1'b0;
        signedB_s = 1'b0;
      end
    endcase
    signA_s    = signedA_s & bus.SrcAE[XLEN-1];
    signB_s    = signedB_s & bus.SrcBE[XLEN-1];
    absA_s     = magnitude(bus.SrcAE, signA_s);
    absB_s     = magnitude(bus.SrcBE, signB_s);
    bZero_s    = (bus.SrcBE == {XLEN{1'b0}});
    overflow_s = signedB_s & bus.funct3E[2] & (bus.SrcAE == MIN_VAL) & (bus.SrcBE == ALL_ONES);
    earlyOut_s = EARLY_OUT & bus.funct3E[2] & (bZero_s | overflow_s);
    if (bus.funct3E[1]) begin
      earlyRes_s = bZero_s ? bus.SrcAE : {XLEN{1'b0}};
    end else begin
      earlyRes_s = bZero_s ? ALL_ONES : MIN_VAL;
    end
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mulSum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, operand_r} : {(XLEN+1){1'b0}});
    remSh_s   = acc_r[2*XLEN-1:XLEN-1];
    remGe_s   = (remSh_s >= {1'b0, operand_r});
    remDiff_s = remSh_s[XLEN-1:0] - operand_r;
    if (state_r == DIV) begin
      stepAcc_s = {(remGe_s ? remDiff_s : remSh_s[XLEN-1:0]), acc_r[XLEN-2:0], remGe_s};
    end else begin
      stepAcc_s = {mulSum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction of the last step's value; B==0 forces an all-ones quotient
  always_comb begin
    prodFix_s = negRes_r ? -stepAcc_s : stepAcc_s;
    quot_s    = divZero_r ? ALL_ONES : magnitude(stepAcc_s[XLEN-1:0], negRes_r);
    remd_s    = magnitude(stepAcc_s[2*XLEN-1:XLEN], signA_r);
    case (funct3_r)
      3'b000:                 finalRes_s = prodFix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalRes_s = prodFix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalRes_s = quot_s;
      default:                finalRes_s = remd_s;
    endcase
  end

  // Control FSM with datapath registers and registered done/result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      count_r   <= '0;
      acc_r     <= '0;
      operand_r <= '0;
      funct3_r  <= 3'b000;
      signA_r   <= 1'b0;
      negRes_r  <= 1'b0;
      divZero_r <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.startE && !bus.FlushE) begin
            funct3_r  <= bus.funct3E;
            signA_r   <= signA_s;
            negRes_r  <= signA_s ^ signB_s;
            divZero_r <= bZero_s;
            count_r   <= '0;
            if (bus.funct3E[2]) begin
              acc_r     <= {{XLEN{1'b0}}, absA_s};
              operand_r <= absB_s;
            end else begin
              acc_r     <= {{XLEN{1'b0}}, absB_s};
              operand_r <= absA_s;
            end
            if (earlyOut_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= earlyRes_s;
            end else if (bus.funct3E[2]) begin
              state_r <= DIV;
            end else begin
              state_r <= MUL;
            end
          end
        end
        MUL, DIV: begin
          if (bus.FlushE) begin
            state_r <= IDLE;
          end else begin
            acc_r   <= stepAcc_s;
            count_r <= count_r + CNT_ONE;
            if (count_r == LAST_STEP) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= finalRes_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stallE  = (bus.startE & ~bus.FlushE & (state_r == IDLE)) | (state_r == MUL) | (state_r == DIV);
  assign bus.doneE   = done_r;
  assign bus.resultE = result_r;

endmodule
